// File: rtl/pipe_latch_hs.sv
// pipe_latch_hs: valid/ready pipeline register with stall, flush, and squashing of the control vector on bubbles.
// Optional PIPE_LATCH_SKID_EN adds one skid entry and a registered in_ready (no comb path from out_ready).
module pipe_latch_hs #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 2,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic              w_accept;
    logic              w_drain;

    assign out_data = r_data;
    assign out_ctrl = r_ctrl;

`ifdef PIPE_LATCH_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_load_in;
    logic              w_load_skid;
    logic              w_pop_skid;
    logic              w_squash;

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready & ~flush;
    assign w_drain   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) r_state <= S_EMPTY;
        else                r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_load_in   = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        w_squash    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_in   = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                    w_squash    = 1'b1;
                end
            end
            S_TWO: begin
                // in_ready is low here, so the only event is the skid moving forward.
                if (w_drain) begin
                    w_state_nxt = S_ONE;
                    w_pop_skid  = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= '0;
            r_ctrl      <= CTRL_RST;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_RST;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_ctrl      <= CTRL_RST;
            r_skid_ctrl <= CTRL_RST;
            r_in_ready  <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt != S_TWO);
            if (w_load_in) begin
                r_data <= in_data;
                r_ctrl <= in_ctrl;
            end else if (w_pop_skid) begin
                r_data <= r_skid_data;
                r_ctrl <= r_skid_ctrl;
            end else if (w_squash) begin
                r_ctrl <= CTRL_RST;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end
`else
    logic r_valid;

    assign out_valid = r_valid;
    assign in_ready  = ~flush & (~r_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_valid & out_ready;

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= CTRL_RST;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
            r_ctrl  <= in_ctrl;
        end else if (w_drain) begin
            // Bubble: payload is kept, control squashed so no downstream write fires.
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_latch_hs.sv
// Bench for pipe_latch_hs: directed scenarios plus random traffic, checked against a queue-based occupancy model.
module tb_pipe_latch_hs;
    localparam int                DATA_W   = 32;
    localparam int                CTRL_W   = 2;
    localparam logic [CTRL_W-1:0] CTRL_RST = 2'b00;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    pipe_latch_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    // Model: beats held by the latch in arrival order, head is what the output shows.
    beat_t             q[$];
    logic [DATA_W-1:0] m_last_data;
    logic              m_ready_reg;
    logic              exp_ready;
    bit                accepted;
    logic [DATA_W-1:0] emitted[$];
    int                checks = 0;
    int                errors = 0;
    int                idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
`ifdef PIPE_LATCH_SKID_EN
        return m_ready_reg;
`else
        return !flush && (q.size() == 0 || out_ready);
`endif
    endfunction

    task automatic drive(input logic f, input logic iv, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    // Called at a negedge: check outputs against the model, clock once, advance the model.
    task automatic cycle(input string tag);
        #1;
        exp_ready = model_ready();
        if (!reset) begin
            check({tag, ":in_ready"},  in_ready,  exp_ready);
            check({tag, ":out_valid"}, out_valid, q.size() != 0);
            check({tag, ":out_data"},  out_data,  (q.size() != 0) ? q[0].data : m_last_data);
            check({tag, ":out_ctrl"},  out_ctrl,  (q.size() != 0) ? q[0].ctrl : CTRL_RST);
            if (out_valid && out_ready && !flush) emitted.push_back(out_data);
        end
        @(posedge clk);
        accepted = 0;
        if (reset) begin
            q.delete();
            m_last_data = '0;
            m_ready_reg = 1'b1;
        end else if (flush) begin
            q.delete();
            m_ready_reg = 1'b0;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                q.push_back('{in_data, in_ctrl});
                accepted = 1;
            end
            m_ready_reg = (q.size() < 2);
        end
        if (q.size() != 0) m_last_data = q[0].data;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        cycle("rst");
        cycle("rst");
        reset = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 32'h1234_5678, 2'b11, 1'b1);
        #1;
        check("t1_valid", out_valid, 1'b0);
        check("t1_data",  out_data,  32'h0);
        check("t1_ctrl",  out_ctrl,  CTRL_RST);
        check("t1_ready", in_ready,  1'b1);
        cycle("t1");

        // Single beat, one-cycle latency
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 2'b11, 1'b1);
        cycle("t2a");
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check("t2_valid", out_valid, 1'b1);
        check("t2_data",  out_data,  32'hDEAD_BEEF);
        check("t2_ctrl",  out_ctrl,  2'b11);
        cycle("t2b");

        // Stream 1..8 with out_ready alternating 1,0
        emitted.delete();
        idx = 1;
        for (int n = 0; n < 60 && (idx <= 8 || q.size() != 0); n++) begin
            drive(1'b0, idx <= 8, (idx <= 8) ? DATA_W'(idx) : $urandom, 2'b01, (n % 2) == 0);
            cycle("t3");
            if (accepted) idx++;
        end
        check("t3_all_sent", idx, 9);
        check("t3_count", emitted.size(), 8);
        for (int i = 0; i < 8 && i < emitted.size(); i++)
            check("t3_order", emitted[i], i + 1);

        // Flush during a stall drops both the held beat and the incoming one
        emitted.delete();
        drive(1'b0, 1'b1, 32'hA5, 2'b10, 1'b0);
        cycle("t4a");
        drive(1'b1, 1'b1, 32'h5A, 2'b11, 1'b0);
        cycle("t4flush");
        drive(1'b0, 1'b0, $urandom, 2'b11, 1'b1);
        #1;
        check("t4_valid", out_valid, 1'b0);
        check("t4_ctrl",  out_ctrl,  2'b00);
        for (int n = 0; n < 3; n++) cycle("t4idle");
        check("t4_none_emitted", emitted.size(), 0);

        // Drain with no new beat leaves a bubble
        drive(1'b0, 1'b1, 32'h77, 2'b11, 1'b1);
        cycle("t5a");
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check("t5_valid_before", out_valid, 1'b1);
        cycle("t5b");
        #1;
        check("t5_valid", out_valid, 1'b0);
        check("t5_ctrl",  out_ctrl,  2'b00);
        cycle("t5c");

`ifdef PIPE_LATCH_SKID_EN
        // Skid fill and drain
        drive(1'b0, 1'b1, 32'h1, 2'b01, 1'b0);
        cycle("t6a");
        drive(1'b0, 1'b1, 32'h2, 2'b01, 1'b0);
        cycle("t6b");
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        #1;
        check("t6_full_ready", in_ready, 1'b0);
        check("t6_full_data",  out_data, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        cycle("t6c");
        #1;
        check("t6_second_data", out_data, 32'h2);
        check("t6_ready_again", in_ready, 1'b1);
        cycle("t6d");
        #1;
        check("t6_empty", out_valid, 1'b0);
        cycle("t6e");
`endif

        // Random traffic with occasional flush
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom,
                  CTRL_W'($urandom), $urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        // Reset while stalled discards the held beat
        drive(1'b0, 1'b1, 32'hCC, 2'b11, 1'b0);
        cycle("rs_a");
        reset = 1'b1;
        cycle("rs_b");
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check("rs_valid", out_valid, 1'b0);
        check("rs_data",  out_data,  32'h0);
        cycle("rs_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
